// File: rtl/toggle_decoder.sv
// toggle_decoder: turns level flips on an asynchronous toggle line back into
// discrete events. Synchronise -> debounce -> saturating pending counter ->
// valid/ready hand-off to the consumer.
module toggle_decoder #(
  parameter int DEBOUNCE_CYCLES = 4,   // extra mismatch samples after the first (1..255)
  parameter int CNT_WIDTH       = 4    // pending counter width
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tog_in,
  input  logic                 evt_ready,
  output logic                 evt_valid,
  output logic [CNT_WIDTH-1:0] evt_pending,
  output logic                 level,
  output logic                 overflow
);

  localparam logic [0:0] STABLE = 1'b0;
  localparam logic [0:0] FILTER = 1'b1;

  localparam logic [7:0]           DEB_LAST = 8'(DEBOUNCE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] PEND_MAX = '1;

  logic                 sync1_q, sync2_q;
  logic                 level_q, level_d;
  logic [0:0]           state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] pend_q, pend_d;
  logic                 ovf_q, ovf_d;
  logic                 accept, take, tog_s;

  assign tog_s = sync2_q;

  // Two-flop synchroniser; tog_in is used nowhere else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= tog_in;
      sync2_q <= sync1_q;
    end
  end

  // Debounce FSM: a level change is accepted only after DEBOUNCE_CYCLES+1
  // consecutive mismatching samples; any return to the old level aborts it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    accept  = 1'b0;
    case (state_q)
      STABLE: begin
        if (tog_s != level_q) begin
          state_d = FILTER;
          cnt_d   = 8'd1;
        end
      end
      default: begin
        if (tog_s == level_q) begin
          state_d = STABLE;
        end else if (cnt_q == DEB_LAST) begin
          level_d = ~level_q;
          accept  = 1'b1;
          state_d = STABLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    endcase
  end

  // Pending counter: saturates at max (flagging a lost event), never underflows.
  // Simultaneous accept and take cancel out, even at max.
  always_comb begin
    take   = evt_valid & evt_ready;
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (accept && !take) begin
      if (pend_q == PEND_MAX) ovf_d  = 1'b1;
      else                    pend_d = pend_q + 1'b1;
    end else if (!accept && take) begin
      pend_d = pend_q - 1'b1;
    end
  end

  // State registers for the filter and the event queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STABLE;
      cnt_q   <= 8'd0;
      level_q <= 1'b0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  assign evt_valid   = (pend_q != '0);
  assign evt_pending = pend_q;
  assign level       = level_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_toggle_decoder.sv
// Directed bench for toggle_decoder: expected output words are queued when
// stimulus is applied and popped/compared once the DUT should have answered.
module tb_toggle_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tog_in = 1'b0;
  logic       evt_ready = 1'b0;
  logic       evt_valid;
  logic [3:0] evt_pending;
  logic       level;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  logic [6:0] exp_q[$];   // {overflow, evt_valid, level, evt_pending}

  toggle_decoder #(.DEBOUNCE_CYCLES(4), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .tog_in(tog_in), .evt_ready(evt_ready),
    .evt_valid(evt_valid), .evt_pending(evt_pending), .level(level),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] pk(input logic o, input logic v, input logic l, input int p);
    return {o, v, l, 4'(p)};
  endfunction

  // advance n rising edges, leave the caller at the following falling edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_out(input logic o, input logic v, input logic l, input int p);
    exp_q.push_back(pk(o, v, l, p));
  endtask

  task automatic check(input string tag);
    logic [6:0] obs, exp;
    obs = {overflow, evt_valid, level, evt_pending};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty, observed %b", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s: observed {ovf,vld,lvl,pend}=%b expected %b", tag, obs, exp);
      end
    end
  endtask

  initial begin
    // reset state
    @(negedge clk);
    expect_out(0, 0, 0, 0); check("reset");
    tick(1);
    rst_n = 1'b1;

    // idle line: nothing ever happens
    for (int i = 0; i < 30; i++) begin
      expect_out(0, 0, 0, 0);
      tick(1);
      check("idle");
    end

    // 3-cycle pulse is rejected as a glitch
    tog_in = 1'b1; tick(3);
    tog_in = 1'b0;
    expect_out(0, 0, 0, 0);
    tick(20); check("glitch");

    // clean rise: accepted exactly at edge 7
    tog_in = 1'b1;
    expect_out(0, 0, 0, 0); tick(6); check("rise_e6");
    expect_out(0, 1, 1, 1); tick(1); check("rise_e7");
    evt_ready = 1'b1;
    expect_out(0, 0, 1, 0); tick(1); check("take");
    evt_ready = 1'b0;

    // 16 toggles with no consumer: saturate at 15, then overflow
    for (int i = 1; i <= 16; i++) begin
      tog_in = ~tog_in;
      expect_out(i >= 16, 1, 1'(~i[0]) ^ 1'b0 ? 1'b1 : 1'b0, (i > 15) ? 15 : i);
      tick(12); check("sat");
    end

    // drain all 15; overflow stays sticky
    evt_ready = 1'b1;
    for (int i = 14; i >= 0; i--) begin
      expect_out(1, i != 0, 1, i);
      tick(1); check("drain");
    end
    // ready with nothing pending must not underflow
    expect_out(1, 0, 1, 0); tick(2); check("no_underflow");
    evt_ready = 1'b0;

    // build 3 pending, then take on the accepting edge
    for (int i = 1; i <= 3; i++) begin
      tog_in = ~tog_in;
      expect_out(1, 1, 1'(i[0] ^ 1'b1), i);
      tick(12); check("build3");
    end
    tog_in = ~tog_in;
    expect_out(1, 1, 0, 3); tick(6); check("pre_accept");
    evt_ready = 1'b1;
    expect_out(1, 1, 1, 3); tick(1); check("accept_and_take");
    expect_out(1, 0, 1, 0); tick(3); check("drain3");
    evt_ready = 1'b0;

    // reset in FILTER with cnt=2, then tog_in=1 held gives exactly one event
    tog_in = 1'b0; tick(4);
    rst_n = 1'b0; tog_in = 1'b1;
    #1;
    expect_out(0, 0, 0, 0); check("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    expect_out(0, 0, 0, 0); tick(6); check("post_rst_e6");
    expect_out(0, 1, 1, 1); tick(1); check("post_rst_e7");
    expect_out(0, 1, 1, 1); tick(20); check("post_rst_single");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // guard against any accidental stall
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

endmodule
